// File: rtl/facto_job_sequencer.sv
// ----------------------------------------------------------------------------
// facto_job_sequencer
//
// Front-end for the factorial core. Operand jobs arrive on a valid/ready
// stream and are buffered in a small FIFO. One job at a time is launched on
// the core through its start/done handshake, guarded by a range check on the
// operand and a watchdog timer. Each job produces exactly one tagged result
// on the output valid/ready stream, in acceptance order.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready producer handshake; in_x operand, in_tag job tag
//   out_valid/out_ready consumer handshake
//   out_result        factorial value (0 on error)
//   out_err           00 ok, 01 range reject, 10 timeout
//   out_tag           tag of the job being reported
//   core_start        one-cycle start pulse to the core
//   core_x            operand presented to the core
//   core_fi           core result
//   core_done         one-cycle completion pulse from the core
//   busy              FSM not idle or FIFO non-empty
//   fifo_level        FIFO occupancy
// ----------------------------------------------------------------------------
module facto_job_sequencer #(
   parameter int XW      = 4,
   parameter int FW      = 32,
   parameter int TW      = 4,
   parameter int DEPTH   = 4,
   parameter int MAX_X   = 12,
   parameter int TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [XW-1:0]            in_x,
   input  logic [TW-1:0]            in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [FW-1:0]            out_result,
   output logic [1:0]               out_err,
   output logic [TW-1:0]            out_tag,
   output logic                     core_start,
   output logic [XW-1:0]            core_x,
   input  logic [FW-1:0]            core_fi,
   input  logic                     core_done,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW  = $clog2(DEPTH) + 1;
   localparam int TMW = $clog2(TIMEOUT);

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_RANGE   = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT,
      ST_EMIT
   } state_t;

   state_t          state_q;

   logic [XW-1:0]   fifoX_q   [DEPTH];
   logic [TW-1:0]   fifoTag_q [DEPTH];
   logic [PW-1:0]   wrPtr_q;
   logic [PW-1:0]   rdPtr_q;
   logic [LW-1:0]   count_q;
   logic [LW-1:0]   count_d;

   logic [TW-1:0]   jobTag_q;
   logic [XW-1:0]   coreX_q;
   logic            coreStart_q;
   logic [TMW-1:0]  timer_q;
   logic            outValid_q;
   logic [FW-1:0]   outResult_q;
   logic [1:0]      outErr_q;
   logic [TW-1:0]   outTag_q;

   logic            push;
   logic            pop;
   logic [XW-1:0]   headX;
   logic [TW-1:0]   headTag;
   logic            headOutOfRange;

   // The FIFO only pops while the FSM is idle, so the head entry is consumed
   // in the same cycle the FSM latches it into the job registers.
   assign in_ready       = (count_q != LW'(DEPTH));
   assign push           = in_valid && in_ready;
   assign pop            = (state_q == ST_IDLE) && (count_q != '0);
   assign headX          = fifoX_q[rdPtr_q];
   assign headTag        = fifoTag_q[rdPtr_q];
   // Widen both sides so a MAX_X beyond the operand range still compares right.
   assign headOutOfRange = (32'(headX) > $unsigned(32'(MAX_X)));

   assign fifo_level = count_q;
   assign busy       = (state_q != ST_IDLE) || (count_q != '0);
   assign core_start = coreStart_q;
   assign core_x     = coreX_q;
   assign out_valid  = outValid_q;
   assign out_result = outResult_q;
   assign out_err    = outErr_q;
   assign out_tag    = outTag_q;

   // Occupancy next-state: a simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + LW'(1);
      end else if (!push && pop) begin
         count_d = count_q - LW'(1);
      end
   end

   // FIFO payload storage; data needs no reset because occupancy gates use.
   always_ff @(posedge clk) begin
      if (push) begin
         fifoX_q[wrPtr_q]   <= in_x;
         fifoTag_q[wrPtr_q] <= in_tag;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wrPtr_q <= wrPtr_q + PW'(1);
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + PW'(1);
         end
         count_q <= count_d;
      end
   end

   // Job sequencing FSM with registered core and result outputs.
   // core_done is only looked at in ST_WAIT, so stray pulses are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         jobTag_q    <= '0;
         coreX_q     <= '0;
         coreStart_q <= 1'b0;
         timer_q     <= '0;
         outValid_q  <= 1'b0;
         outResult_q <= '0;
         outErr_q    <= ERR_OK;
         outTag_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pop) begin
                  jobTag_q <= headTag;
                  coreX_q  <= headX;
                  if (headOutOfRange) begin
                     outResult_q <= '0;
                     outErr_q    <= ERR_RANGE;
                     outTag_q    <= headTag;
                     outValid_q  <= 1'b1;
                     state_q     <= ST_EMIT;
                  end else begin
                     coreStart_q <= 1'b1;
                     state_q     <= ST_LAUNCH;
                  end
               end
            end

            ST_LAUNCH: begin
               coreStart_q <= 1'b0;
               timer_q     <= '0;
               state_q     <= ST_WAIT;
            end

            // Done takes priority over an expiring watchdog in the same cycle.
            ST_WAIT: begin
               if (core_done) begin
                  outResult_q <= core_fi;
                  outErr_q    <= ERR_OK;
                  outTag_q    <= jobTag_q;
                  outValid_q  <= 1'b1;
                  state_q     <= ST_EMIT;
               end else if (timer_q == TMW'(TIMEOUT - 1)) begin
                  outResult_q <= '0;
                  outErr_q    <= ERR_TIMEOUT;
                  outTag_q    <= jobTag_q;
                  outValid_q  <= 1'b1;
                  state_q     <= ST_EMIT;
               end else begin
                  timer_q <= timer_q + TMW'(1);
               end
            end

            ST_EMIT: begin
               if (out_ready) begin
                  outValid_q <= 1'b0;
                  state_q    <= ST_IDLE;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_facto_job_sequencer.sv
// ----------------------------------------------------------------------------
// tb_facto_job_sequencer
//
// Directed bench for facto_job_sequencer. Stimulus pushes the expected result
// for each accepted job into a queue; a monitor pops and compares whenever the
// DUT completes an output handshake. A simple core model answers start pulses
// after a programmable delay (negative delay = never answers).
// ----------------------------------------------------------------------------
module tb_facto_job_sequencer;

   localparam int XW    = 4;
   localparam int FW    = 32;
   localparam int TW    = 4;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [FW-1:0] result;
      logic [1:0]    err;
      logic [TW-1:0] tag;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [XW-1:0]  in_x;
   logic [TW-1:0]  in_tag;
   logic           out_valid;
   logic           out_ready;
   logic [FW-1:0]  out_result;
   logic [1:0]     out_err;
   logic [TW-1:0]  out_tag;
   logic           core_start;
   logic [XW-1:0]  core_x;
   logic [FW-1:0]  core_fi;
   logic           core_done;
   logic           busy;
   logic [2:0]     fifo_level;

   exp_t           sbQueue[$];
   int             checksTotal = 0;
   int             checksPassed = 0;
   int             coreDelay = 10;
   int             startCount = 0;
   logic [XW-1:0]  lastCoreX = '0;

   facto_job_sequencer #(
      .XW(XW), .FW(FW), .TW(TW), .DEPTH(DEPTH), .MAX_X(12), .TIMEOUT(64)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_x       (in_x),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_err    (out_err),
      .out_tag    (out_tag),
      .core_start (core_start),
      .core_x     (core_x),
      .core_fi    (core_fi),
      .core_done  (core_done),
      .busy       (busy),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   // Factorial table used only by the core model to produce core_fi.
   function automatic logic [FW-1:0] coreFact(input logic [XW-1:0] x);
      logic [FW-1:0] f;
      f = 1;
      for (int i = 2; i <= int'(x); i++) f = f * FW'(i);
      return f;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checksTotal++;
      if (actual === expected) checksPassed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   // Drives one job and queues its expected result once the handshake is certain.
   task automatic applyStimulus(input logic [XW-1:0] x, input logic [TW-1:0] tag,
                                input logic [FW-1:0] expResult, input logic [1:0] expErr);
      exp_t item;
      int   n;
      @(negedge clk);
      in_valid = 1'b1;
      in_x     = x;
      in_tag   = tag;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checksTotal++;
         $display("[TB] FAIL push_tag%0d: in_ready stayed 0, expected 1 within 200 cycles", tag);
         in_valid = 1'b0;
      end else begin
         item.result = expResult;
         item.err    = expErr;
         item.tag    = tag;
         sbQueue.push_back(item);
      end
   endtask

   task automatic releaseInput();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic waitDrain(input string name, input int bound);
      int n;
      n = 0;
      while (sbQueue.size() != 0 && n < bound) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, 64'(sbQueue.size()), 64'd0);
      repeat (3) @(negedge clk);
   endtask

   // Core model: answers each start after coreDelay cycles with the factorial.
   initial begin
      int d;
      core_done = 1'b0;
      core_fi   = '0;
      forever begin
         @(negedge clk);
         if (rst_n && core_start) begin
            d = coreDelay;
            if (d >= 0) begin
               repeat (d) @(negedge clk);
               core_done = 1'b1;
               core_fi   = coreFact(core_x);
               @(negedge clk);
               core_done = 1'b0;
            end
         end
      end
   end

   // Counts every cycle core_start is high, so a stretched pulse shows up.
   always @(negedge clk) begin
      if (core_start) begin
         startCount <= startCount + 1;
         lastCoreX  <= core_x;
      end
   end

   // Monitor: compares each completed output handshake against the scoreboard.
   initial begin
      exp_t expItem;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n && out_valid && out_ready) begin
            if (sbQueue.size() == 0) begin
               checksTotal++;
               $display("[TB] FAIL unexpected_result: got result=%0d err=%0d tag=%0d, expected no output",
                        out_result, out_err, out_tag);
            end else begin
               expItem = sbQueue.pop_front();
               checkOutput($sformatf("result_tag%0d", expItem.tag),
                           64'({out_result, out_err, out_tag}), 64'(expItem));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation still running, expected completion");
      $fatal(1, "[TB] global timeout");
   end

   initial begin
      int n;
      int startSnap;
      logic [FW-1:0] expFact [7];
      expFact = '{32'd1, 32'd1, 32'd2, 32'd6, 32'd24, 32'd120, 32'd720};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_x      = '0;
      in_tag    = '0;
      out_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_fifo_level", 64'(fifo_level), 64'd0);
      checkOutput("rst_in_ready",   64'(in_ready),   64'd1);
      checkOutput("rst_out_valid",  64'(out_valid),  64'd0);
      checkOutput("rst_busy",       64'(busy),       64'd0);
      checkOutput("rst_core_start", 64'(core_start), 64'd0);
      checkOutput("rst_outputs", 64'({out_result, out_err, out_tag, core_x}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Nominal: 5! = 120
      $display("[TB] nominal job");
      coreDelay = 10;
      startSnap = startCount;
      applyStimulus(4'd5, 4'd3, 32'd120, 2'b00);
      releaseInput();
      waitDrain("drain_nominal", 200);
      checkOutput("nominal_start_cycles", 64'(startCount - startSnap), 64'd1);
      checkOutput("nominal_core_x", 64'(lastCoreX), 64'd5);

      // Range reject: 13 > 12, no core start, output two cycles after handshake
      $display("[TB] range reject");
      startSnap = startCount;
      applyStimulus(4'd13, 4'd1, 32'd0, 2'b01);
      n = 0;
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         n++;
         #1;
      end while (!out_valid && n < 10);
      checkOutput("reject_latency", 64'(n), 64'd2);
      waitDrain("drain_reject", 50);
      checkOutput("reject_no_start", 64'(startCount - startSnap), 64'd0);

      // Timeout: done arrives far too late and must be ignored
      $display("[TB] timeout");
      coreDelay = 70;
      applyStimulus(4'd7, 4'd2, 32'd0, 2'b10);
      n = 0;
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         n++;
         #1;
      end while (!core_start && n < 10);
      @(negedge clk);
      n = 0;
      #1;
      while (!out_valid && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput("timeout_cycles_after_start", 64'(n), 64'd64);
      waitDrain("drain_timeout", 50);
      repeat (100) @(negedge clk);

      // Done and watchdog expiry in the same cycle: done wins
      $display("[TB] done/timeout coincidence");
      coreDelay = 64;
      applyStimulus(4'd3, 4'd4, 32'd6, 2'b00);
      releaseInput();
      waitDrain("drain_coincide", 200);

      // Backpressure: 5 accepted, 6th blocked until the output drains
      $display("[TB] backpressure");
      coreDelay = 2;
      @(negedge clk);
      out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(XW'(i), TW'(i), expFact[i], 2'b00);
      end
      @(negedge clk);
      in_x   = 4'd6;
      in_tag = 4'd6;
      #1;
      checkOutput("full_in_ready", 64'(in_ready), 64'd0);
      checkOutput("full_level", 64'(fifo_level), 64'd4);
      @(negedge clk);
      out_ready = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (in_ready) begin
         sbQueue.push_back(exp_t'{result: 32'd720, err: 2'b00, tag: 4'd6});
      end else begin
         checksTotal++;
         $display("[TB] FAIL sixth_accept: in_ready stayed 0, expected 1 after release");
      end
      releaseInput();
      waitDrain("drain_backpressure", 400);

      // Simultaneous push and pop at level 2
      $display("[TB] push/pop at level 2");
      @(negedge clk);
      out_ready = 1'b0;
      applyStimulus(4'd2, 4'd7, 32'd2, 2'b00);
      applyStimulus(4'd3, 4'd8, 32'd6, 2'b00);
      applyStimulus(4'd4, 4'd9, 32'd24, 2'b00);
      releaseInput();
      n = 0;
      #1;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput("level_before_pushpop", 64'(fifo_level), 64'd2);
      @(negedge clk);
      out_ready = 1'b1;
      applyStimulus(4'd5, 4'd10, 32'd120, 2'b00);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checkOutput("level_after_pushpop", 64'(fifo_level), 64'd2);
      waitDrain("drain_pushpop", 200);

      // Reset in WAIT with three jobs queued
      $display("[TB] reset mid-operation");
      coreDelay = -1;
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(XW'(i), TW'(i), expFact[i], 2'b00);
      end
      releaseInput();
      repeat (3) @(negedge clk);
      #1;
      checkOutput("pre_reset_level", 64'(fifo_level), 64'd3);
      checkOutput("pre_reset_busy", 64'(busy), 64'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      sbQueue.delete();
      checkOutput("midrst_level_ready", 64'({fifo_level, in_ready}), 64'({3'd0, 1'b1}));
      checkOutput("midrst_busy_start", 64'({busy, core_start, out_valid}), 64'd0);
      checkOutput("midrst_outputs", 64'({out_result, out_err, out_tag, core_x}), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      coreDelay = 3;
      applyStimulus(4'd4, 4'd11, 32'd24, 2'b00);
      releaseInput();
      waitDrain("drain_after_reset", 200);

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule

// File: doc/facto_job_sequencer.md
Name: facto_job_sequencer

Overview:
- Front-end stage that feeds the factorial core and collects its results.
- Accepts operand jobs from a producer over a valid/ready stream and buffers them in a small FIFO.
- Launches one factorial computation at a time through the core's start/Done handshake, with range checking and a watchdog timeout.
- Returns each result, tagged, over a valid/ready output stream.

Parameters:
- XW, 4: operand width (matches core X).
- FW, 32: result width (matches core fi_out).
- TW, 4: job tag width.
- DEPTH, 4: input FIFO depth; power of 2, ≥2.
- MAX_X, 12: largest operand forwarded to core; larger operands are rejected.
- TIMEOUT, 64: cycles allowed from launch to core Done; ≥2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- in_valid  in  1  producer job valid
- in_ready  out  1  sequencer can accept job
- in_x  in  XW  operand
- in_tag  in  TW  job tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  FW  factorial value (0 on error)
- out_err  out  2  00 ok, 01 range reject, 10 timeout
- out_tag  out  TW  tag of the job being reported
- core_start  out  1  one-cycle start pulse to core
- core_x  out  XW  operand to core
- core_fi  in  FW  core result
- core_done  in  1  core completion pulse (one cycle)
- busy  out  1  FSM not IDLE or FIFO non-empty
- fifo_level  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset and clock: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values (registered outputs and state):
  - FIFO empty, so fifo_level=0 and in_ready=1.
  - out_valid=0, out_result=0, out_err=0, out_tag=0.
  - core_start=0, core_x=0, busy=0, FSM in IDLE, watchdog timer=0.
- Reset mid-operation: any in-flight job and all queued jobs are discarded. No result is emitted for them.
- FIFO:
  - in_ready = !full, combinational from the occupancy count.
  - Push on in_valid && in_ready. The entry is visible to the FSM the next cycle; there is no bypass.
  - Push and pop in the same cycle are both performed and leave fifo_level unchanged.
  - Push while full is impossible (in_ready=0). Pop only occurs when the FIFO is non-empty.
  - Pointers wrap modulo DEPTH.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop and latch x/tag into job registers; drive core_x = x.
    - If x > MAX_X: out_result=0, out_err=01, go to EMIT. The core is not started.
    - Otherwise go to LAUNCH.
  - LAUNCH: core_start=1 for exactly this cycle; clear the timer; go to WAIT.
  - WAIT: the timer increments each cycle.
    - On core_done=1: capture core_fi into out_result, out_err=00, go to EMIT.
    - Otherwise, when timer==TIMEOUT-1: out_result=0, out_err=10, go to EMIT.
    - If core_done and timeout coincide, done wins.
  - EMIT: out_valid=1; out_result, out_err and out_tag are held stable. When out_ready=1: out_valid drops next cycle and the FSM returns to IDLE.
- Core handshake rules:
  - core_x is held constant from LAUNCH through the end of WAIT.
  - core_done outside WAIT is ignored.
  - Only one job is in flight at the core at any time.
- Timing and throughput:
  - Minimum latency from input handshake to out_valid: 3 cycles + core compute time.
  - Back-to-back throughput: one job per (core time + 4) cycles.
- Ordering: results are emitted strictly in acceptance order.
- Backpressure: out_ready held low stalls in EMIT. The FIFO continues filling until full, then in_ready=0.
- Arithmetic: comparison x > MAX_X is unsigned. The timer is clog2(TIMEOUT) bits and never wraps, because WAIT exits at TIMEOUT-1.

Test Plan:
- Nominal: push x=5, tag=3 with a core model that pulses done 10 cycles after start → exactly one core_start pulse with core_x=5; then out_valid with result=120, err=00, tag=3.
- Range reject: push x=13, tag=1 (MAX_X=12) → no core_start; out_valid with result=0, err=01, tag=1 within 2 cycles of the pop.
- Timeout: core model never asserts done → out_valid with err=10, result=0 exactly 64 cycles after the core_start pulse; a later core_done is ignored.
- Backpressure/full: out_ready=0, push 6 jobs x=1..6 back-to-back → 5 accepted (1 in job, 4 in FIFO); in_ready=0 and fifo_level=4 on the 6th. Releasing out_ready yields results 1, 2, 6, 24, 120 in order; the 6th is then accepted.
- Simultaneous push/pop with FIFO at level 2 → level stays 2.
- Done/timeout coincidence: done arrives on cycle TIMEOUT-1 → err=00 with captured core_fi.
- Reset mid-WAIT with 3 jobs queued: assert rst_n=0 → all outputs return to reset values immediately and in_ready=1; after release, no stale result appears and a fresh x=4 job returns 24.
